// File: rtl/inst_memory_prog.sv
// -----------------------------------------------------------------------------
// inst_memory_prog
//
// Run-time loadable instruction memory for the RISC-V core. After reset the
// array is zero-filled by hardware, one word per cycle. Once it is clear, the
// memory serves fetches with one cycle of latency and accepts program loads.
//
// Parameters
//   NUM_INST  depth in 32-bit words (>= 2)
//   NOP_INST  word returned for a faulting fetch (addi x0,x0,0)
//   PC_BASE   byte address that maps to word 0
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; restarts the clear from any state
//   load_valid   load request
//   load_ready   high when a load would be accepted (READY state)
//   load_addr    word index to write; indices >= NUM_INST are dropped
//   load_data    instruction word to write
//   load_strb    byte enables (bit i covers bits [8i+7:8i])
//   fetch_req    fetch request, accepted in READY
//   fetch_pc     byte-addressed program counter
//   fetch_valid  fetch_inst/fetch_fault valid (one cycle after acceptance)
//   fetch_inst   fetched word, or NOP_INST on a fault
//   fetch_fault  misaligned or out-of-range fetch
//   busy         high while the array is being cleared
//
// Build option
//   INST_MEM_BYTE_WE_EN  when defined, load_strb selects which bytes of the
//                        addressed word change; otherwise every accepted load
//                        writes the full word and load_strb is ignored.
// -----------------------------------------------------------------------------
module inst_memory_prog #(
  parameter int          NUM_INST = 128,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter logic [31:0] PC_BASE  = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [$clog2(NUM_INST)-1:0] load_addr,
  input  logic [31:0]                 load_data,
  input  logic [3:0]                  load_strb,
  input  logic                        fetch_req,
  input  logic [31:0]                 fetch_pc,
  output logic                        fetch_valid,
  output logic [31:0]                 fetch_inst,
  output logic                        fetch_fault,
  output logic                        busy
);

  localparam int          AW       = $clog2(NUM_INST);
  localparam logic [31:0] DEPTH    = 32'(NUM_INST);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_INST - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_t        state_reg;
  state_t        state_next;
  logic [AW-1:0] cnt_reg;
  logic [AW-1:0] cnt_next;
  logic          clear_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The clear walks every index once; the cycle that writes the last word is
  // also the last CLEAR cycle, so CLEAR lasts exactly NUM_INST cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST_IDX) begin
          state_next = READY;
          cnt_next   = '0;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    load_ready = 1'b0;
    clear_we   = 1'b0;
    case (state_reg)
      CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
      end
      READY: begin
        load_ready = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write port: the clear and the load port share one write path.
  // ---------------------------------------------------------------------------
  logic [3:0]    load_be;
  logic          load_in_range;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

`ifdef INST_MEM_BYTE_WE_EN
  assign load_be = load_strb;
`else
  // Byte enables are not honoured in this build; the port is kept so the
  // interface is identical in both configurations.
  logic unused_load_strb;
  assign unused_load_strb = ^load_strb;
  assign load_be          = 4'hF;
`endif

  // Only reachable when NUM_INST is not a power of two.
  assign load_in_range = (32'(load_addr) < DEPTH);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    if (!reset) begin
      if (clear_we) begin
        wr_en   = 1'b1;
        wr_addr = cnt_reg;
        wr_data = 32'h0;
        wr_be   = 4'hF;
      end else if (load_ready && load_valid && load_in_range) begin
        wr_en   = 1'b1;
        wr_addr = load_addr;
        wr_data = load_data;
        wr_be   = load_be;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch decode
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_offset;
  logic [29:0]   fetch_idx;
  logic          fetch_bad;
  logic          fetch_accept;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // Wrap-around subtraction: a PC below PC_BASE becomes a huge offset and
  // therefore lands in the out-of-range fault case.
  assign fetch_offset = fetch_pc - PC_BASE;
  assign fetch_idx    = fetch_offset[31:2];
  assign fetch_bad    = (fetch_offset[1:0] != 2'b00) || ({2'b00, fetch_idx} >= DEPTH);
  assign fetch_accept = (state_reg == READY) && fetch_req && !reset;
  assign rd_addr      = fetch_idx[AW-1:0];
  // Faulting fetches skip the array so the index never leaves its bounds.
  assign rd_en        = fetch_accept && !fetch_bad;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane so byte enables map onto independent
  // write ports. The registered read samples the array before the same-edge
  // write lands, which gives read-before-write for a colliding load.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [NUM_INST];
    logic [7:0] lane_q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) begin
        lane_mem[wr_addr] <= wr_data[8*gi +: 8];
      end
      if (rd_en) begin
        lane_q_reg <= lane_mem[rd_addr];
      end
    end

    assign rd_word[8*gi +: 8] = lane_q_reg;
  end

  // ---------------------------------------------------------------------------
  // Fetch response
  // ---------------------------------------------------------------------------
  logic fetch_valid_reg;
  logic fetch_fault_reg;
  // Selects NOP_INST instead of the RAM output. Set on reset (the RAM read
  // register has no reset) and after a faulting fetch; it only changes on an
  // accepted fetch so the outputs hold between requests.
  logic nop_sel_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_reg <= 1'b0;
      fetch_fault_reg <= 1'b0;
      nop_sel_reg     <= 1'b1;
    end else begin
      fetch_valid_reg <= fetch_accept;
      if (fetch_accept) begin
        fetch_fault_reg <= fetch_bad;
        nop_sel_reg     <= fetch_bad;
      end
    end
  end

  assign fetch_valid = fetch_valid_reg;
  assign fetch_fault = fetch_fault_reg;
  assign fetch_inst  = nop_sel_reg ? NOP_INST : rd_word;

endmodule

// File: tb/tb_inst_memory_prog.sv
// -----------------------------------------------------------------------------
// tb_inst_memory_prog
//
// Exercises inst_memory_prog with directed steps and a randomized load/fetch
// stream checked against an array model of the program memory. A second,
// small instance (6 words, non-zero PC_BASE) covers out-of-range load indices
// and base-relative addressing.
// -----------------------------------------------------------------------------
module tb_inst_memory_prog;

  localparam int          N       = 128;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] BASE    = 32'h00000000;
  localparam int          SN      = 6;
  localparam logic [31:0] SBASE   = 32'h00001000;

  logic        clk;
  logic        reset;

  logic        load_valid;
  logic        load_ready;
  logic [6:0]  load_addr;
  logic [31:0] load_data;
  logic [3:0]  load_strb;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_fault;
  logic        busy;

  logic        s_load_valid;
  logic        s_load_ready;
  logic [2:0]  s_load_addr;
  logic [31:0] s_load_data;
  logic [3:0]  s_load_strb;
  logic        s_fetch_req;
  logic [31:0] s_fetch_pc;
  logic        s_fetch_valid;
  logic [31:0] s_fetch_inst;
  logic        s_fetch_fault;
  logic        s_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [N];
  logic [31:0] exp_inst;
  logic        exp_fault;

  inst_memory_prog #(.NUM_INST(N), .NOP_INST(NOP), .PC_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_strb(load_strb),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_fault(fetch_fault),
    .busy(busy)
  );

  inst_memory_prog #(.NUM_INST(SN), .NOP_INST(NOP), .PC_BASE(SBASE)) dut_s (
    .clk(clk), .reset(reset),
    .load_valid(s_load_valid), .load_ready(s_load_ready), .load_addr(s_load_addr),
    .load_data(s_load_data), .load_strb(s_load_strb),
    .fetch_req(s_fetch_req), .fetch_pc(s_fetch_pc),
    .fetch_valid(s_fetch_valid), .fetch_inst(s_fetch_inst), .fetch_fault(s_fetch_fault),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // New contents of a word after an accepted load.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = new_w;
`ifdef INST_MEM_BYTE_WE_EN
    for (int b = 0; b < 4; b++) begin
      if (!strb[b]) r[8*b +: 8] = old_w[8*b +: 8];
    end
`else
    r = (strb === 4'bxxxx) ? old_w : new_w;
`endif
    return r;
  endfunction

  // One READY-state cycle on the main instance: apply inputs, predict the
  // fetch result from the pre-write model, check it, then commit the load.
  task automatic drive(input logic lv, input logic [6:0] la, input logic [31:0] ld,
                       input logic [3:0] ls, input logic fr, input logic [31:0] pc);
    logic [31:0] off;
    load_valid = lv; load_addr = la; load_data = ld; load_strb = ls;
    fetch_req  = fr; fetch_pc  = pc;
    if (fr) begin
      off = pc - BASE;
      if ((off % 4) != 0 || (off / 4) >= N) begin
        exp_inst  = NOP;
        exp_fault = 1'b1;
      end else begin
        exp_inst  = model[int'(off / 4)];
        exp_fault = 1'b0;
      end
    end
    @(negedge clk);
    $display("cycle: ld=%b a=%0d d=%h s=%b fr=%b pc=%h -> v=%b inst=%h flt=%b",
             lv, la, ld, ls, fr, pc, fetch_valid, fetch_inst, fetch_fault);
    chk1("fetch_valid", fetch_valid, fr);
    chk32("fetch_inst", fetch_inst, exp_inst);
    chk1("fetch_fault", fetch_fault, exp_fault);
    chk1("busy_ready", busy, 1'b0);
    chk1("load_ready", load_ready, 1'b1);
    if (lv) model[int'(la)] = merge(model[int'(la)], ld, ls);
  endtask

  // Releases reset and checks the clear: length, no fetch responses and no
  // effect from a load or fetch presented throughout.
  task automatic wait_clear();
    int n;
    load_valid = 1'b1; load_addr = 7'd3; load_data = 32'hDEADBEEF; load_strb = 4'hF;
    fetch_req  = 1'b1; fetch_pc  = 32'h40;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk1("clear_fetch_valid", fetch_valid, 1'b0);
    end while (busy === 1'b1 && n < 1000);
    $display("clear: busy cycles %0d", n);
    chk32("clear_len", 32'(n), 32'(N));
    chk1("clear_load_ready", load_ready, 1'b1);
    chk32("clear_inst_nop", fetch_inst, NOP);
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    exp_inst  = NOP;
    exp_fault = 1'b0;
  endtask

  task automatic s_step(input logic lv, input logic [2:0] la, input logic [31:0] ld,
                        input logic fr, input logic [31:0] pc);
    s_load_valid = lv; s_load_addr = la; s_load_data = ld; s_load_strb = 4'hF;
    s_fetch_req  = fr; s_fetch_pc  = pc;
    @(negedge clk);
    $display("small: ld=%b a=%0d d=%h fr=%b pc=%h -> v=%b inst=%h flt=%b",
             lv, la, ld, fr, pc, s_fetch_valid, s_fetch_inst, s_fetch_fault);
  endtask

  initial begin
    logic [31:0] be_exp;
    logic [6:0]  ra;
    logic [31:0] rpc;

    reset = 1'b1;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_strb = '0;
    fetch_req = 1'b0; fetch_pc = '0;
    s_load_valid = 1'b0; s_load_addr = '0; s_load_data = '0; s_load_strb = '0;
    s_fetch_req = 1'b0; s_fetch_pc = '0;
    exp_inst = NOP; exp_fault = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_load_ready", load_ready, 1'b0);
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk32("rst_fetch_inst", fetch_inst, NOP);
    chk1("rst_fetch_fault", fetch_fault, 1'b0);

    // Clear, then fetch 0x40 and the word a load targeted during the clear
    wait_clear();
    drive(0, 0, 0, 0, 1, 32'h40);
    chk32("post_clear_0x40", fetch_inst, 32'h0);
    drive(0, 0, 0, 0, 1, 32'hC);

    // Load then back-to-back fetch
    drive(1, 7'd0, 32'h00400293, 4'hF, 0, 0);
    drive(1, 7'd1, 32'h45678337, 4'hF, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0);
    chk32("word0", fetch_inst, 32'h00400293);
    drive(0, 0, 0, 0, 1, 32'h4);
    chk32("word1", fetch_inst, 32'h45678337);

    // Faults and hold behaviour
    drive(0, 0, 0, 0, 1, 32'h6);
    chk1("misaligned_fault", fetch_fault, 1'b1);
    drive(0, 0, 0, 0, 1, 32'h200);
    chk32("range_nop", fetch_inst, NOP);
    drive(0, 0, 0, 0, 1, 32'h4);
    drive(0, 0, 0, 0, 0, 32'h0);

    // Read-before-write
    drive(1, 7'd5, 32'h11111111, 4'hF, 0, 0);
    drive(1, 7'd5, 32'h22222222, 4'hF, 1, 32'h14);
    chk32("rbw_old", fetch_inst, 32'h11111111);
    drive(0, 0, 0, 0, 1, 32'h14);
    chk32("rbw_new", fetch_inst, 32'h22222222);

    // Byte enables
    drive(1, 7'd2, 32'hAABBCCDD, 4'hF, 0, 0);
    drive(1, 7'd2, 32'h11223344, 4'b0101, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h8);
`ifdef INST_MEM_BYTE_WE_EN
    be_exp = 32'hAA22CC44;
`else
    be_exp = 32'h11223344;
`endif
    chk32("byte_we", fetch_inst, be_exp);

`ifdef INST_MEM_BYTE_WE_EN
    // A zero strobe leaves the word untouched
    drive(1, 7'd2, 32'h55555555, 4'b0000, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h8);
    chk32("strb_zero", fetch_inst, be_exp);
`endif

    // Small instance: out-of-range load indices and base-relative fetches
    s_step(1, 3'd5, 32'hCAFEF00D, 0, 0);
    s_step(1, 3'd6, 32'h12345678, 0, 0);
    s_step(1, 3'd7, 32'h9ABCDEF0, 0, 0);
    s_step(0, 0, 0, 1, SBASE + 32'h14);
    chk1("s_valid", s_fetch_valid, 1'b1);
    chk32("s_word5", s_fetch_inst, 32'hCAFEF00D);
    chk1("s_word5_fault", s_fetch_fault, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s_step(0, 0, 0, 1, SBASE + 32'(4 * i));
      chk32("s_unchanged", s_fetch_inst, 32'h0);
      chk1("s_unchanged_fault", s_fetch_fault, 1'b0);
    end
    s_step(0, 0, 0, 1, SBASE + 32'h18);
    chk32("s_idx6_nop", s_fetch_inst, NOP);
    chk1("s_idx6_fault", s_fetch_fault, 1'b1);
    s_step(0, 0, 0, 1, SBASE - 32'h4);
    chk1("s_below_base_fault", s_fetch_fault, 1'b1);
    s_step(0, 0, 0, 1, SBASE + 32'h2);
    chk1("s_misaligned_fault", s_fetch_fault, 1'b1);
    s_step(0, 0, 0, 0, 0);
    chk1("s_idle_valid", s_fetch_valid, 1'b0);
    chk32("s_idle_hold", s_fetch_inst, NOP);

    // Randomized load/fetch stream
    for (int i = 0; i < 400; i++) begin
      ra = 7'($urandom_range(0, N - 1));
      case ($urandom_range(0, 5))
        0, 1, 2: rpc = BASE + 32'($urandom_range(0, N - 1)) * 4;
        3:       rpc = BASE + 32'(ra) * 4;
        4:       rpc = BASE + 32'($urandom_range(0, N - 1)) * 4 + 32'($urandom_range(1, 3));
        default: rpc = $urandom;
      endcase
      drive(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), rpc);
    end

    // Reset during back-to-back fetches
    drive(0, 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h4);
    reset = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h8;
    @(negedge clk);
    chk1("midrst_valid", fetch_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b1);
    chk1("midrst_load_ready", load_ready, 1'b0);
    chk32("midrst_inst", fetch_inst, NOP);
    wait_clear();
    drive(0, 0, 0, 0, 1, 32'h14);
    chk32("midrst_word5_zero", fetch_inst, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h8);
    drive(0, 0, 0, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_memory_prog.md
Name: inst_memory_prog

Overview:
- Parametrised, synchronous-read instruction memory for the RISC-V core; successor to the fixed, combinational program ROM.
- Program is loaded at run time through a load port rather than hard-wired, so the same RTL serves every test program.
- After reset, hardware zero-fills the array, then serves fetches with 1-cycle latency.
- Flags misaligned and out-of-range PCs and returns a NOP for them.

Parameters:
- NUM_INST, 128: depth in 32-bit words; any value ≥ 2. AW = $clog2(NUM_INST).
- NOP_INST, 32'h00000013: word returned on a fault (addi x0,x0,0).
- PC_BASE, 32'h00000000: byte address of word 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  load accepted this cycle when load_valid is also high.
- load_addr  in  AW  word index to write.
- load_data  in  32  instruction word.
- load_strb  in  4  byte enables; bit i covers bits [8i+7:8i].
- fetch_req  in  1  fetch request.
- fetch_pc  in  32  byte-addressed PC.
- fetch_valid  out  1  fetch_inst/fetch_fault are valid; asserted 1 cycle after an accepted request.
- fetch_inst  out  32  fetched instruction.
- fetch_fault  out  1  misaligned or out-of-range fetch.
- busy  out  1  high while clearing.

Behaviour:
- Reset:
  - State goes to CLEAR and the clear counter goes to 0.
  - Outputs: load_ready = 0, fetch_valid = 0, fetch_inst = NOP_INST, fetch_fault = 0, busy = 1.
  - Reset asserted in any state, including mid-clear or mid-load, restarts the clear.
- CLEAR state:
  - Writes 32'h0 to word[cnt] each cycle; cnt increments by 1.
  - After the cycle writing word NUM_INST-1, moves to READY. CLEAR lasts exactly NUM_INST cycles after reset deasserts.
  - load_ready = 0. Loads and fetches are ignored (not queued), and fetch_valid stays 0.
- READY state:
  - busy = 0 and load_ready = 1.
  - A load is accepted when load_valid and load_ready are both high.
  - load_addr ≥ NUM_INST: write dropped; no other effect.
- Fetch:
  - Accepted in READY when fetch_req = 1.
  - offset = fetch_pc - PC_BASE (32-bit wrap-around arithmetic). idx = offset >> 2.
  - Next cycle: fetch_valid = 1.
  - Normal case: fetch_inst = word[idx], fetch_fault = 0.
  - Fault case, when offset[1:0] ≠ 0 or idx ≥ NUM_INST: fetch_inst = NOP_INST, fetch_fault = 1.
  - No request: fetch_valid = 0. fetch_inst and fetch_fault hold their last values.
  - Back-to-back requests give one result per cycle; throughput is 1 fetch/cycle.
- Simultaneous load and fetch to the same word in one cycle: read-before-write. The fetch returns the old contents; the next fetch sees the new word.
- Array holds no reset value beyond the hardware clear. The clear guarantees all-zero contents before first use.

Optional Feature:
- Macro INST_MEM_BYTE_WE_EN.
- Defined: load_strb is honoured; only the enabled bytes of word[load_addr] change. load_strb = 0 makes the accepted load a no-op.
- Undefined: load_strb is ignored; every accepted load writes the full 32-bit word. The port remains present so the interface is stable.

Test Plan:
- Clear timing: release reset with NUM_INST = 128 → busy = 1 for exactly 128 cycles, then load_ready = 1. A fetch at pc 0x40 during clear gives no fetch_valid. A fetch at pc 0x40 after clear returns 0x00000000.
- Load then fetch: load word 0 = 0x00400293 and word 1 = 0x45678337. Fetch pc 0x0 then pc 0x4 on consecutive cycles → fetch_valid on the next two cycles with 0x00400293 then 0x45678337, fetch_fault = 0.
- Faults: fetch pc 0x6 → fetch_inst = 0x00000013, fetch_fault = 1. Fetch pc 0x200 with NUM_INST = 128 → same result. Load with load_addr out of range → array unchanged.
- Read-before-write: word 5 = 0x11111111. Same cycle, load word 5 = 0x22222222 and fetch pc 0x14 → returns 0x11111111. Next fetch of pc 0x14 → 0x22222222.
- Reset mid-operation: assert reset for 1 cycle during back-to-back fetches → fetch_valid = 0 next cycle, busy = 1, CLEAR restarts, and the previously loaded word reads 0 after the clear.
- Byte enables (INST_MEM_BYTE_WE_EN): word 2 = 0xAABBCCDD, load 0x11223344 with load_strb = 4'b0101 → fetch pc 0x8 returns 0xAA22CC44. Without the macro → returns 0x11223344.
